// File: rtl/vid_pkt_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vid_pkt_pkg : Avalon-ST Video packet constants and packetizer state enum
// Revision    : 1.0
// ---------------------------------------------------------------------------
package vid_pkt_pkg;

  localparam logic [3:0] PKT_VIDEO      = 4'h0;
  localparam logic [3:0] PKT_CTRL       = 4'hF;
  localparam logic [3:0] INTERLACE_PROG = 4'h3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CTRL_HDR = 3'd1,
    CTRL_B1  = 3'd2,
    CTRL_B2  = 3'd3,
    CTRL_B3  = 3'd4,
    DATA_HDR = 3'd5,
    PIXELS   = 3'd6,
    PAD      = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/vid_packetizer_avst_out_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// avst_out_reg : Avalon-ST source holding register (ready latency 0)
// Revision     : 1.0
// ---------------------------------------------------------------------------
module avst_out_reg #(
  parameter int unsigned DW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          beat_valid,
  input  logic [DW-1:0] beat_data,
  input  logic          beat_sop,
  input  logic          beat_eop,
  input  logic          src_ready,
  output logic          can_load,
  output logic          src_valid,
  output logic [DW-1:0] src_data,
  output logic          src_sop,
  output logic          src_eop
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;

  assign can_load = !valid_q || src_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    if (can_load) begin
      valid_d = beat_valid;
      data_d  = beat_data;
      sop_d   = beat_sop;
      eop_d   = beat_eop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign src_valid = valid_q;
  assign src_data  = data_q;
  assign src_sop   = sop_q;
  assign src_eop   = eop_q;

endmodule
`default_nettype wire

// File: rtl/vid_packetizer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vid_packetizer : frame-flagged pixel stream to Avalon-ST Video packets
// Revision       : 1.0
// ---------------------------------------------------------------------------
module vid_packetizer
  import vid_pkt_pkg::*;
#(
  parameter int unsigned WIDTH     = 640,
  parameter int unsigned HEIGHT    = 480,
  parameter bit          SEND_CTRL = 1'b1,
  parameter logic [11:0] PAD_VALUE = 12'h000
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        in_valid,
  input  logic [11:0] in_data,
  input  logic        in_sof,
  output logic        in_ready,
  output logic        src_valid,
  output logic [11:0] src_data,
  output logic        src_startofpacket,
  output logic        src_endofpacket,
  input  logic        src_ready,
  output logic        err_short,
  output logic        err_long
);

  localparam int unsigned NPIX   = WIDTH * HEIGHT;
  localparam int unsigned PCNT_W = $clog2(NPIX + 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(NPIX - 1);

  localparam logic [15:0] W16 = 16'(WIDTH);
  localparam logic [15:0] H16 = 16'(HEIGHT);
  localparam logic [11:0] CTRL_HDR_WORD = {8'h00, PKT_CTRL};
  localparam logic [11:0] DATA_HDR_WORD = {8'h00, PKT_VIDEO};
  localparam logic [11:0] CTRL_B1_WORD  = {W16[7:4], W16[11:8], W16[15:12]};
  localparam logic [11:0] CTRL_B2_WORD  = {H16[11:8], H16[15:12], W16[3:0]};
  localparam logic [11:0] CTRL_B3_WORD  = {INTERLACE_PROG, H16[3:0], H16[7:4]};

  state_t              state_q, state_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic                err_short_q, err_short_d;
  logic                err_long_q, err_long_d;
  logic                disc_q, disc_d;

  logic                beat_valid;
  logic [11:0]         beat_data;
  logic                beat_sop;
  logic                beat_eop;
  logic                can_load;
  logic                in_ready_w;
  logic                pix_last;

  assign pix_last = (pcnt_q == PCNT_LAST);

  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    disc_d      = disc_q;
    beat_valid  = 1'b0;
    beat_data   = '0;
    beat_sop    = 1'b0;
    beat_eop    = 1'b0;
    in_ready_w  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_sof) begin
          // The first header is loaded straight from IDLE to hit the cycle-1 beat.
          beat_valid = 1'b1;
          beat_sop   = 1'b1;
          beat_data  = SEND_CTRL ? CTRL_HDR_WORD : DATA_HDR_WORD;
          disc_d     = 1'b0;
          if (can_load) state_d = SEND_CTRL ? CTRL_B1 : PIXELS;
          else          state_d = SEND_CTRL ? CTRL_HDR : DATA_HDR;
        end else begin
          in_ready_w = !in_sof;
          if (in_valid) begin
            err_long_d = !disc_q;
            disc_d     = 1'b1;
          end
        end
      end
      CTRL_HDR: begin
        beat_valid = 1'b1;
        beat_sop   = 1'b1;
        beat_data  = CTRL_HDR_WORD;
        if (can_load) state_d = CTRL_B1;
      end
      CTRL_B1: begin
        beat_valid = 1'b1;
        beat_data  = CTRL_B1_WORD;
        if (can_load) state_d = CTRL_B2;
      end
      CTRL_B2: begin
        beat_valid = 1'b1;
        beat_data  = CTRL_B2_WORD;
        if (can_load) state_d = CTRL_B3;
      end
      CTRL_B3: begin
        beat_valid = 1'b1;
        beat_eop   = 1'b1;
        beat_data  = CTRL_B3_WORD;
        if (can_load) state_d = DATA_HDR;
      end
      DATA_HDR: begin
        beat_valid = 1'b1;
        beat_sop   = 1'b1;
        beat_data  = DATA_HDR_WORD;
        if (can_load) state_d = PIXELS;
      end
      PIXELS: begin
        if (in_sof && (pcnt_q != '0)) begin
          // Early SOF: hold that pixel back and pad out the current packet.
          if (in_valid) begin
            state_d     = PAD;
            err_short_d = 1'b1;
          end
        end else begin
          in_ready_w = can_load;
          beat_valid = in_valid;
          beat_data  = in_data;
          beat_eop   = pix_last;
          if (in_valid && can_load) begin
            if (pix_last) begin
              pcnt_d  = '0;
              state_d = IDLE;
            end else begin
              pcnt_d = pcnt_q + PCNT_W'(1);
            end
          end
        end
      end
      PAD: begin
        beat_valid = 1'b1;
        beat_data  = PAD_VALUE;
        beat_eop   = pix_last;
        if (can_load) begin
          if (pix_last) begin
            pcnt_d  = '0;
            state_d = IDLE;
          end else begin
            pcnt_d = pcnt_q + PCNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q     <= IDLE;
      pcnt_q      <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      disc_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      disc_q      <= disc_d;
    end
  end

  avst_out_reg #(
    .DW (12)
  ) u_out_reg (
    .clk        (clk_clk),
    .rst_n      (reset_reset_n),
    .beat_valid (beat_valid),
    .beat_data  (beat_data),
    .beat_sop   (beat_sop),
    .beat_eop   (beat_eop),
    .src_ready  (src_ready),
    .can_load   (can_load),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_sop    (src_startofpacket),
    .src_eop    (src_endofpacket)
  );

  assign in_ready  = reset_reset_n && in_ready_w;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;

endmodule
`default_nettype wire

// File: tb/tb_vid_packetizer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vid_packetizer : directed self-checking bench for vid_packetizer
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_vid_packetizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_sof, in_ready;
  logic [11:0] in_data;
  logic        src_valid, src_sop, src_eop, src_ready;
  logic [11:0] src_data;
  logic        err_short, err_long;

  logic        in_valid1, in_sof1, in_ready1;
  logic [11:0] in_data1;
  logic        src_valid1, src_sop1, src_eop1, src_ready1;
  logic [11:0] src_data1;
  logic        err_short1, err_long1;

  int          n_checks = 0;
  int          n_err    = 0;
  int          n_short  = 0;
  int          n_long   = 0;
  int          n_hold   = 0;
  logic        bp_on    = 1'b0;
  logic        prev_stall = 1'b0;
  logic [14:0] prev_beat  = '0;
  logic [13:0] got_q[$];
  logic [13:0] exp_q[$];

  always #5 clk = ~clk;

  vid_packetizer #(
    .WIDTH (4), .HEIGHT (2), .SEND_CTRL (1'b1), .PAD_VALUE (12'hABC)
  ) dut (
    .clk_clk (clk), .reset_reset_n (rst_n),
    .in_valid (in_valid), .in_data (in_data), .in_sof (in_sof), .in_ready (in_ready),
    .src_valid (src_valid), .src_data (src_data),
    .src_startofpacket (src_sop), .src_endofpacket (src_eop), .src_ready (src_ready),
    .err_short (err_short), .err_long (err_long)
  );

  vid_packetizer #(
    .WIDTH (4), .HEIGHT (2), .SEND_CTRL (1'b0), .PAD_VALUE (12'hABC)
  ) dut_nc (
    .clk_clk (clk), .reset_reset_n (rst_n),
    .in_valid (in_valid1), .in_data (in_data1), .in_sof (in_sof1), .in_ready (in_ready1),
    .src_valid (src_valid1), .src_data (src_data1),
    .src_startofpacket (src_sop1), .src_endofpacket (src_eop1), .src_ready (src_ready1),
    .err_short (err_short1), .err_long (err_long1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sink-side monitor: beats transfer at the next edge when valid & ready here.
  always @(negedge clk) begin
    if (prev_stall) begin
      n_hold++;
      check("hold", {17'd0, src_valid, src_sop, src_eop, src_data}, {17'd0, prev_beat});
    end
    prev_stall = src_valid && !src_ready;
    prev_beat  = {src_valid, src_sop, src_eop, src_data};
    if (src_valid && src_ready) got_q.push_back({src_sop, src_eop, src_data});
    if (err_short) n_short++;
    if (err_long)  n_long++;
  end

  always @(posedge clk) begin
    #1;
    if (bp_on) src_ready = ~src_ready;
    else       src_ready = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_px(input logic [11:0] d, input logic sof, output int waits);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 60) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) check("send timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [11:0] base, input int n);
    int w;
    for (int i = 0; i < n; i++) send_px(base + 12'(i), (i == 0), w);
  endtask

  task automatic exp_ctrl();
    exp_q.push_back({2'b10, 12'h00F});
    exp_q.push_back({2'b00, 12'h000});
    exp_q.push_back({2'b00, 12'h004});
    exp_q.push_back({2'b01, 12'h320});
    exp_q.push_back({2'b10, 12'h000});
  endtask

  task automatic exp_frame(input logic [11:0] base);
    exp_ctrl();
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, (i == 7), base + 12'(i)});
  endtask

  task automatic compare_stream(input string tag);
    check($sformatf("%s count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s beat%0d", tag, i), {18'd0, got_q[i]}, {18'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    in_valid1 = 1'b0; in_sof1 = 1'b0; in_data1 = '0;
    src_ready = 1'b1; src_ready1 = 1'b1;
    tick(3);
    check("reset outs", {src_valid, src_sop, src_eop, src_data, in_ready, err_short, err_long}, 0);
    check("reset outs nc", {src_valid1, src_sop1, src_eop1, src_data1, in_ready1, err_short1, err_long1}, 0);
    rst_n = 1'b1;

    // SEND_CTRL=0: data header in cycle 1, first pixel in cycle 2
    in_valid1 = 1'b1; in_sof1 = 1'b1; in_data1 = 12'h001;
    @(negedge clk);
    check("nc c0 in_ready", {31'd0, in_ready1}, 0);
    @(negedge clk);
    check("nc c1 beat", {17'd0, src_valid1, src_sop1, src_eop1, src_data1}, {17'd0, 3'b110, 12'h000});
    check("nc c1 in_ready", {31'd0, in_ready1}, 1);
    @(posedge clk); #1;
    in_sof1 = 1'b0; in_data1 = 12'h002;
    @(negedge clk);
    check("nc c2 beat", {17'd0, src_valid1, src_sop1, src_eop1, src_data1}, {17'd0, 3'b100, 12'h001});
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    tick(2);

    // Basic frame, including in_ready first high in cycle 5
    send_px(12'h001, 1'b1, w);
    check("basic first wait", w, 5);
    for (int i = 1; i < 8; i++) send_px(12'h001 + 12'(i), 1'b0, w);
    tick(4);
    exp_frame(12'h001);
    compare_stream("basic");

    // Backpressure
    bp_on = 1'b1; n_hold = 0;
    send_frame(12'h001, 8);
    tick(12);
    bp_on = 1'b0;
    tick(2);
    exp_frame(12'h001);
    compare_stream("bp");
    check("bp stalls seen", {31'd0, n_hold > 0}, 1);

    // Short frame then a full frame starting at the held SOF pixel
    n_short = 0; n_long = 0;
    send_frame(12'h001, 5);
    send_frame(12'h011, 8);
    tick(4);
    exp_ctrl();
    for (int i = 0; i < 5; i++) exp_q.push_back({2'b00, 12'h001 + 12'(i)});
    exp_q.push_back({2'b00, 12'hABC});
    exp_q.push_back({2'b00, 12'hABC});
    exp_q.push_back({2'b01, 12'hABC});
    exp_frame(12'h011);
    compare_stream("short");
    check("short err_short", n_short, 1);
    check("short err_long", n_long, 0);

    // Long frame: surplus pixels dropped with in_ready high
    n_short = 0; n_long = 0;
    send_frame(12'h021, 8);
    for (int i = 0; i < 3; i++) begin
      send_px(12'h07F, 1'b0, w);
      check($sformatf("surplus%0d wait", i), w, 0);
    end
    send_frame(12'h031, 8);
    tick(4);
    exp_frame(12'h021);
    exp_frame(12'h031);
    compare_stream("long");
    check("long err_long", n_long, 1);
    check("long err_short", n_short, 0);

    // Reset mid-packet
    send_frame(12'h041, 3);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst in_ready", {31'd0, in_ready}, 0);
    @(posedge clk); #1;
    check("rst mid outs", {src_valid, src_sop, src_eop, src_data, in_ready, err_short, err_long}, 0);
    rst_n = 1'b1;
    tick(3);
    exp_ctrl();
    for (int i = 0; i < 3; i++) exp_q.push_back({2'b00, 12'h041 + 12'(i)});
    compare_stream("rst abort");
    send_frame(12'h051, 8);
    tick(4);
    exp_frame(12'h051);
    compare_stream("rst fresh");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
